stm_segment_ctrl: RTL and testbench

STM_SEGMENT_CTRL -- requirements
Module: stm_segment_ctrl

---
 rtl/stm_segment_ctrl_if.sv | 48 ++++
 rtl/stm_segment_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stm_segment_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stm_segment_ctrl_if.sv
// stm_segment_ctrl_if: request/tick inputs, per-segment settings and status outputs
// of the STM segment controller.
//   master : drives UPDATE, REQ_*, CYCLE/REP/MODE/SOUND_SPEED; observes outputs
//   slave  : the controller itself
// With STM_SEGMENT_CTRL_IMMEDIATE_EN defined an extra REQ_IMMEDIATE input exists.
interface stm_segment_ctrl_if #(
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned IDX_W        = 16,
  parameter int unsigned SPEED_W      = 32
);
  localparam int unsigned SEG_W = $clog2(NUM_SEGMENTS);

  logic               UPDATE;
  logic               REQ_VALID;
  logic [SEG_W-1:0]   REQ_SEGMENT;
`ifdef STM_SEGMENT_CTRL_IMMEDIATE_EN
  logic               REQ_IMMEDIATE;
`endif
  logic [IDX_W-1:0]   CYCLE       [NUM_SEGMENTS];
  logic [15:0]        REP         [NUM_SEGMENTS];
  logic               MODE        [NUM_SEGMENTS];
  logic [SPEED_W-1:0] SOUND_SPEED [NUM_SEGMENTS];

  logic [SEG_W-1:0]   SEGMENT;
  logic [IDX_W-1:0]   IDX;
  logic               MODE_OUT;
  logic [SPEED_W-1:0] SOUND_SPEED_OUT;
  logic               START;
  logic               STOP;
  logic               LOOP_DONE;
  logic               REQ_ERR;

  modport master (
`ifdef STM_SEGMENT_CTRL_IMMEDIATE_EN
    output REQ_IMMEDIATE,
`endif
    output UPDATE, REQ_VALID, REQ_SEGMENT, CYCLE, REP, MODE, SOUND_SPEED,
    input  SEGMENT, IDX, MODE_OUT, SOUND_SPEED_OUT, START, STOP, LOOP_DONE, REQ_ERR
  );

  modport slave (
`ifdef STM_SEGMENT_CTRL_IMMEDIATE_EN
    input  REQ_IMMEDIATE,
`endif
    input  UPDATE, REQ_VALID, REQ_SEGMENT, CYCLE, REP, MODE, SOUND_SPEED,
    output SEGMENT, IDX, MODE_OUT, SOUND_SPEED_OUT, START, STOP, LOOP_DONE, REQ_ERR
  );
endinterface

// File: rtl/stm_segment_ctrl.sv
// stm_segment_ctrl: steps an index through the active STM segment on every UPDATE
// tick, counts loop repetitions and switches segments on request at a wrap.
// Ports:
//   CLK, RST : rising-edge clock, asynchronous active-high reset
//   bus      : stm_segment_ctrl_if.slave (UPDATE, REQ_*, per-segment CYCLE/REP/
//              MODE/SOUND_SPEED in; SEGMENT, IDX, MODE_OUT, SOUND_SPEED_OUT,
//              START, STOP, LOOP_DONE, REQ_ERR out, all registered)
// Optional: STM_SEGMENT_CTRL_IMMEDIATE_EN adds REQ_IMMEDIATE, which lets a request
//   take effect on the next UPDATE instead of waiting for a wrap.
module stm_segment_ctrl #(
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned IDX_W        = 16,
  parameter int unsigned SPEED_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  stm_segment_ctrl_if.slave     bus
);
  localparam int unsigned SEG_W = $clog2(NUM_SEGMENTS);
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;
  localparam logic [1:0] S_STOPPED = 2'd3;

  localparam logic [CNT_W-1:0] REP_INF   = 16'hFFFF;
  localparam logic [SEG_W:0]   SEG_LIMIT = (SEG_W+1)'(NUM_SEGMENTS);

  logic [1:0]         state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_vld_q, req_vld_d;
  logic [SEG_W-1:0]   req_seg_q, req_seg_d;
  logic               req_imm_q, req_imm_d;
  logic               start_q;
  logic               loop_done_q, loop_done_d;
  logic               req_err_q, req_err_d;
  logic               stop_q, stop_d;

  logic               req_ok_c;
  logic               at_end_c;
  logic               load_c;
  logic               req_imm_in_c;

`ifdef STM_SEGMENT_CTRL_IMMEDIATE_EN
  assign req_imm_in_c = bus.REQ_IMMEDIATE;
`else
  assign req_imm_in_c = 1'b0;
`endif

  // Next-state: the UPDATE is applied under the current state first, then any
  // request arriving in the same cycle is registered on top of that result.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    cnt_d       = cnt_q;
    req_vld_d   = req_vld_q;
    req_seg_d   = req_seg_q;
    req_imm_d   = req_imm_q;
    loop_done_d = 1'b0;
    load_c      = 1'b0;

    req_ok_c  = bus.REQ_VALID && ({1'b0, bus.REQ_SEGMENT} < SEG_LIMIT);
    req_err_d = bus.REQ_VALID && !req_ok_c;
    at_end_c  = (idx_q == bus.CYCLE[seg_q]);

    if (bus.UPDATE) begin
      case (state_q)
        S_IDLE, S_STOPPED: load_c = req_vld_q;
        S_RUN: begin
          if (at_end_c) begin
            loop_done_d = 1'b1;
            // Out of repetitions: park on the last index instead of wrapping.
            if (cnt_q == '0 && bus.REP[seg_q] != REP_INF) begin
              state_d = S_STOPPED;
            end else begin
              idx_d = '0;
              if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_PENDING: begin
          if (at_end_c || req_imm_q) begin
            loop_done_d = at_end_c;
            load_c      = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Switch to the stored segment with freshly latched settings.
    if (load_c) begin
      state_d   = S_RUN;
      seg_d     = req_seg_q;
      idx_d     = '0;
      mode_d    = bus.MODE[req_seg_q];
      speed_d   = bus.SOUND_SPEED[req_seg_q];
      cnt_d     = bus.REP[req_seg_q];
      req_vld_d = 1'b0;
      req_imm_d = 1'b0;
    end

    // Last valid request wins; a running segment waits for it in PENDING.
    if (req_ok_c) begin
      req_vld_d = 1'b1;
      req_seg_d = bus.REQ_SEGMENT;
      req_imm_d = req_imm_in_c;
      if (state_d == S_RUN) state_d = S_PENDING;
    end

    stop_d = (state_d == S_IDLE) || (state_d == S_STOPPED);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      seg_q       <= '0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      speed_q     <= '0;
      cnt_q       <= '0;
      req_vld_q   <= 1'b0;
      req_seg_q   <= '0;
      req_imm_q   <= 1'b0;
      start_q     <= 1'b0;
      loop_done_q <= 1'b0;
      req_err_q   <= 1'b0;
      stop_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      cnt_q       <= cnt_d;
      req_vld_q   <= req_vld_d;
      req_seg_q   <= req_seg_d;
      req_imm_q   <= req_imm_d;
      start_q     <= bus.UPDATE;
      loop_done_q <= loop_done_d;
      req_err_q   <= req_err_d;
      stop_q      <= stop_d;
    end
  end

  assign bus.SEGMENT         = seg_q;
  assign bus.IDX             = idx_q;
  assign bus.MODE_OUT        = mode_q;
  assign bus.SOUND_SPEED_OUT = speed_q;
  assign bus.START           = start_q;
  assign bus.STOP            = stop_q;
  assign bus.LOOP_DONE       = loop_done_q;
  assign bus.REQ_ERR         = req_err_q;
endmodule

// File: tb/tb_stm_segment_ctrl.sv
// Bench for stm_segment_ctrl: a segment-level model checked every cycle against
// the main instance, plus literal expectations for the key scenarios. A second
// instance with five segments exercises the out-of-range request path.
module tb_stm_segment_ctrl;
  localparam int unsigned NS    = 4;
  localparam int unsigned IW    = 16;
  localparam int unsigned SW    = 32;
  localparam int unsigned SEG_W = $clog2(NS);
  localparam int unsigned NS5   = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  stm_segment_ctrl_if #(.NUM_SEGMENTS(NS), .IDX_W(IW), .SPEED_W(SW)) bus ();
  stm_segment_ctrl_if #(.NUM_SEGMENTS(NS5), .IDX_W(IW), .SPEED_W(SW)) bus5 ();

  stm_segment_ctrl #(.NUM_SEGMENTS(NS), .IDX_W(IW), .SPEED_W(SW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave));
  stm_segment_ctrl #(.NUM_SEGMENTS(NS5), .IDX_W(IW), .SPEED_W(SW)) dut5 (
    .CLK(CLK), .RST(RST), .bus(bus5.slave));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: a segment is either running (possibly with a queued request) or not.
  bit     m_run = 0, m_have_req = 0;
  int     m_req_seg = 0, m_seg = 0, m_idx = 0, m_loops = 0;
  bit     m_mode = 0;
  longint m_speed = 0;
  bit     m_start = 0, m_ld = 0, m_err = 0;

  task automatic m_load(input int s);
    m_seg = s; m_idx = 0; m_run = 1; m_have_req = 0;
    m_mode  = bus.MODE[s];
    m_speed = longint'(bus.SOUND_SPEED[s]);
    m_loops = int'(bus.REP[s]);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_run = 0; m_have_req = 0; m_req_seg = 0; m_seg = 0; m_idx = 0; m_loops = 0;
      m_mode = 0; m_speed = 0; m_start = 0; m_ld = 0; m_err = 0;
    end else begin
      bit at_end;
      m_start = bus.UPDATE;
      m_ld    = 0;
      m_err   = bus.REQ_VALID && (int'(bus.REQ_SEGMENT) >= NS);
      if (bus.UPDATE) begin
        if (!m_run) begin
          if (m_have_req) m_load(m_req_seg);
        end else begin
          at_end = (m_idx == int'(bus.CYCLE[m_seg]));
          if (at_end) m_ld = 1;
          if (at_end && m_have_req) m_load(m_req_seg);
          else if (at_end) begin
            if (m_loops == 0 && bus.REP[m_seg] != 16'hFFFF) m_run = 0;
            else begin
              m_idx = 0;
              if (m_loops > 0) m_loops--;
            end
          end else m_idx++;
        end
      end
      if (bus.REQ_VALID && int'(bus.REQ_SEGMENT) < NS) begin
        m_have_req = 1;
        m_req_seg  = int'(bus.REQ_SEGMENT);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("segment",   longint'(bus.SEGMENT),         longint'(m_seg));
      chk("idx",       longint'(bus.IDX),             longint'(m_idx));
      chk("mode_out",  longint'(bus.MODE_OUT),        longint'(m_mode));
      chk("speed_out", longint'(bus.SOUND_SPEED_OUT), m_speed);
      chk("start",     longint'(bus.START),           longint'(m_start));
      chk("stop",      longint'(bus.STOP),            longint'(!m_run));
      chk("loop_done", longint'(bus.LOOP_DONE),       longint'(m_ld));
      chk("req_err",   longint'(bus.REQ_ERR),         longint'(m_err));
    end
  end

  task automatic cyc(input bit upd, input bit rv, input int rseg);
    @(negedge CLK);
    bus.UPDATE      = upd;
    bus.REQ_VALID   = rv;
    bus.REQ_SEGMENT = SEG_W'(rseg);
  endtask

  // One UPDATE followed by an idle cycle; outputs then show that UPDATE's result.
  task automatic upd1();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  int exp1[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 3, 3};
  int exp2[4]  = '{2, 3, 4, 0};
  int ld_cnt;
  int stop_seen;
  int guard;

  initial begin
    RST = 1'b1;
    bus.UPDATE = 0; bus.REQ_VALID = 0; bus.REQ_SEGMENT = '0;
    bus5.UPDATE = 0; bus5.REQ_VALID = 0; bus5.REQ_SEGMENT = '0;
`ifdef STM_SEGMENT_CTRL_IMMEDIATE_EN
    bus.REQ_IMMEDIATE = 0;
    bus5.REQ_IMMEDIATE = 0;
`endif
    bus.CYCLE[0] = 16'd4; bus.REP[0] = 16'hFFFF; bus.MODE[0] = 1'b0; bus.SOUND_SPEED[0] = 32'd340;
    bus.CYCLE[1] = 16'd3; bus.REP[1] = 16'd1;    bus.MODE[1] = 1'b0; bus.SOUND_SPEED[1] = 32'd1480;
    bus.CYCLE[2] = 16'd2; bus.REP[2] = 16'd0;    bus.MODE[2] = 1'b1; bus.SOUND_SPEED[2] = 32'd5000;
    bus.CYCLE[3] = 16'd1; bus.REP[3] = 16'hFFFF; bus.MODE[3] = 1'b1; bus.SOUND_SPEED[3] = 32'd777;
    for (int i = 0; i < int'(NS5); i++) begin
      bus5.CYCLE[i] = 16'd2; bus5.REP[i] = 16'd0; bus5.MODE[i] = 1'(i % 2);
      bus5.SOUND_SPEED[i] = 32'(100 + i);
    end

    @(negedge CLK);
    chk_en = 1'b1;
    cyc(0, 0, 0);
    chk("reset_stop", longint'(bus.STOP), 1);
    chk("reset_idx",  longint'(bus.IDX), 0);
    @(negedge CLK) RST = 1'b0;

    // Segment 1, CYCLE=3, one extra loop, then parks at IDX=3.
    cyc(0, 1, 1);
    ld_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      upd1();
      chk($sformatf("s1_idx%0d", i), longint'(bus.IDX), longint'(exp1[i]));
      if (bus.LOOP_DONE) ld_cnt++;
    end
    chk("s1_loop_done_cnt", longint'(ld_cnt), 2);
    chk("s1_stop_end", longint'(bus.STOP), 1);

    // Segment 0 running; request segment 2 at IDX=1, switch at the wrap.
    cyc(0, 1, 0);
    upd1();
    upd1();
    chk("s0_idx1", longint'(bus.IDX), 1);
    cyc(0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      upd1();
      chk($sformatf("sw_idx%0d", i), longint'(bus.IDX), longint'(exp2[i]));
    end
    chk("sw_segment", longint'(bus.SEGMENT), 2);
    chk("sw_mode", longint'(bus.MODE_OUT), 1);
    chk("sw_loop_done", longint'(bus.LOOP_DONE), 1);

    // Two requests before the wrap: the later one wins.
    cyc(0, 1, 1);
    upd1();
    cyc(0, 1, 3);
    upd1();
    upd1();
    chk("last_wins_seg", longint'(bus.SEGMENT), 3);
    chk("last_wins_idx", longint'(bus.IDX), 0);
    chk("last_wins_speed", longint'(bus.SOUND_SPEED_OUT), 777);

    // Request coinciding with UPDATE, then a request for the active segment.
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("coinc_idx", longint'(bus.IDX), 1);
    upd1();
    chk("coinc_seg", longint'(bus.SEGMENT), 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) upd1();
    chk("self_restart_idx", longint'(bus.IDX), 0);
    chk("self_restart_ld", longint'(bus.LOOP_DONE), 1);

    // Infinite repetition on segment 3 (CYCLE=1).
    cyc(0, 1, 3);
    guard = 0;
    while (bus.SEGMENT != 2'd3 && guard < 20) begin
      upd1();
      guard++;
    end
    chk("reach_seg3", longint'(bus.SEGMENT), 3);
    ld_cnt = 0; stop_seen = 0;
    for (int i = 0; i < 100; i++) begin
      upd1();
      if (bus.LOOP_DONE) ld_cnt++;
      if (bus.STOP) stop_seen++;
    end
    chk("inf_loop_done_cnt", longint'(ld_cnt), 50);
    chk("inf_stop_seen", longint'(stop_seen), 0);

    // CYCLE=0 wraps on every UPDATE.
    bus.CYCLE[3] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      upd1();
      chk("cyc0_idx", longint'(bus.IDX), 0);
      chk("cyc0_ld", longint'(bus.LOOP_DONE), 1);
    end
    bus.CYCLE[3] = 16'd1;

    // Reset while PENDING.
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("pend_idx", longint'(bus.IDX), 1);
    chk("pend_start", longint'(bus.START), 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_seg",   longint'(bus.SEGMENT), 0);
    chk("rst_idx",   longint'(bus.IDX), 0);
    chk("rst_mode",  longint'(bus.MODE_OUT), 0);
    chk("rst_speed", longint'(bus.SOUND_SPEED_OUT), 0);
    chk("rst_start", longint'(bus.START), 0);
    chk("rst_stop",  longint'(bus.STOP), 1);
    @(negedge CLK) RST = 1'b0;
    upd1();
    chk("post_rst_start", longint'(bus.START), 1);
    chk("post_rst_idx",   longint'(bus.IDX), 0);
    chk("post_rst_stop",  longint'(bus.STOP), 1);
    cyc(0, 0, 0);
    chk("post_rst_start_off", longint'(bus.START), 0);

    // Out-of-range request on the five-segment instance.
    @(negedge CLK); bus5.REQ_VALID = 1; bus5.REQ_SEGMENT = 3'd5;
    @(negedge CLK); bus5.REQ_VALID = 0;
    chk("err5_pulse", longint'(bus5.REQ_ERR), 1);
    chk("err5_stop",  longint'(bus5.STOP), 1);
    @(negedge CLK);
    chk("err5_pulse_end", longint'(bus5.REQ_ERR), 0);
    bus5.UPDATE = 1;
    @(negedge CLK); bus5.UPDATE = 0;
    chk("err5_no_load_stop", longint'(bus5.STOP), 1);
    chk("err5_start", longint'(bus5.START), 1);
    @(negedge CLK); bus5.REQ_VALID = 1; bus5.REQ_SEGMENT = 3'd4;
    @(negedge CLK); bus5.REQ_VALID = 0;
    chk("ok5_no_err", longint'(bus5.REQ_ERR), 0);
    bus5.UPDATE = 1;
    @(negedge CLK); bus5.UPDATE = 0;
    chk("ok5_seg",  longint'(bus5.SEGMENT), 4);
    chk("ok5_stop", longint'(bus5.STOP), 0);
    chk("ok5_mode", longint'(bus5.MODE_OUT), 0);

    chk_en = 1'b0;
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
